// File: rtl/moving_average_pow2.sv
// Runtime-selectable 2^N-tap moving average: circular sample buffer plus running sum.
// Optional round-half-up divide when MOVAVG_ROUND_EN is defined (default: truncate toward -inf).
module moving_average_pow2 #(
  parameter int DATA_WIDTH   = 16,
  parameter int LOG2_MAX_LEN = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ce,
  input  logic signed [DATA_WIDTH-1:0]          din,
  input  logic [$clog2(LOG2_MAX_LEN+1)-1:0]     log2_len,
  output logic signed [DATA_WIDTH-1:0]          dout,
  output logic                                  dout_valid,
  output logic                                  filled
);

  localparam int LW    = $clog2(LOG2_MAX_LEN + 1);
  localparam int PW    = LOG2_MAX_LEN;
  localparam int FW    = LOG2_MAX_LEN + 1;
  localparam int AW    = DATA_WIDTH + LOG2_MAX_LEN;
  localparam int DEPTH = 1 << LOG2_MAX_LEN;
  localparam logic [LW-1:0] MAX_L = LW'(LOG2_MAX_LEN);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  logic signed [AW-1:0]         acc, acc_n;
  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic [FW-1:0]                fill_cnt, fill_n, win, win_n;
  logic [LW-1:0]                len_q, len_n, len_clamp;
  logic                         upd_q, filled_n, change;
  logic signed [DATA_WIDTH-1:0] old;
  logic signed [AW-1:0]         rnd, sum_r, quo;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    len_clamp = (log2_len > MAX_L) ? MAX_L : log2_len;
    change    = (len_clamp != len_q);
    win       = FW'(1) << len_q;
    rd_ptr    = wr_ptr - win[PW-1:0];
    // Stale RAM contents are never read until the window has really been filled.
    old       = (fill_cnt == win) ? mem[rd_ptr] : '0;

    acc_n  = acc;
    fill_n = fill_cnt;
    len_n  = len_q;
    if (change) begin
      len_n = len_clamp;
      if (ce) begin
        acc_n  = AW'(din);
        fill_n = FW'(1);
      end else begin
        acc_n  = '0;
        fill_n = '0;
      end
    end else if (ce) begin
      acc_n  = acc + AW'(din) - AW'(old);
      fill_n = (fill_cnt == win) ? win : fill_cnt + FW'(1);
    end
    win_n    = FW'(1) << len_n;
    filled_n = (fill_n == win_n);
  end

  always_comb begin
`ifdef MOVAVG_ROUND_EN
    rnd   = (len_q == '0) ? '0 : (AW'(1) << (len_q - LW'(1)));
    sum_r = acc + rnd;
`else
    rnd   = '0;
    sum_r = acc;
`endif
    quo = sum_r >>> len_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      len_q      <= '0;
      upd_q      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      filled     <= 1'b0;
    end else begin
      acc        <= acc_n;
      fill_cnt   <= fill_n;
      len_q      <= len_n;
      filled     <= filled_n;
      upd_q      <= ce;
      dout_valid <= upd_q;
      if (ce)    wr_ptr <= wr_ptr + PW'(1);
      // acc already holds the sample consumed one edge earlier; dout follows it here.
      if (upd_q) dout <= quo[DATA_WIDTH-1:0];
    end
  end

  // NOTE: the sample RAM is deliberately not reset; fill_cnt masks whatever it holds.
  always_ff @(posedge clk) begin
    if (ce) mem[wr_ptr] <= din;
  end

endmodule

// File: tb/tb_moving_average_pow2.sv
// Directed-vector bench for moving_average_pow2 (DATA_WIDTH=16, LOG2_MAX_LEN=5).
// Expected values follow the build: MOVAVG_ROUND_EN selects the rounded column.
module tb_moving_average_pow2;

  logic               clk = 1'b0;
  logic               rst;
  logic               ce;
  logic signed [15:0] din;
  logic [2:0]         log2_len;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               filled;

  int checks = 0;
  int errors = 0;

`ifdef MOVAVG_ROUND_EN
  localparam int RAMP [8] = '{2, 4, 6, 8, 9, 11, 13, 15};
  localparam int NEG_FIRST = -2;
  localparam int IMP       = 4;
  localparam int WC_FIRST  = 8;
  localparam int WRAP_AVG  = 16;
`else
  localparam int RAMP [8] = '{1, 3, 5, 7, 9, 11, 13, 15};
  localparam int NEG_FIRST = -2;
  localparam int IMP       = 3;
  localparam int WC_FIRST  = 7;
  localparam int WRAP_AVG  = 15;
`endif

  moving_average_pow2 #(.DATA_WIDTH(16), .LOG2_MAX_LEN(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .din        (din),
    .log2_len   (log2_len),
    .dout       (dout),
    .dout_valid (dout_valid),
    .filled     (filled)
  );

  always #5 clk = ~clk;

  // Consume one sample, then return #1 after the edge where its average lands on dout.
  task automatic send(input logic signed [15:0] d);
    @(posedge clk); #1;
    ce  = 1'b1;
    din = d;
    @(posedge clk); #1;
    ce  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; ce = 1'b0; din = '0; log2_len = 3'd3;
    #2;
    checks++;
    if (dout !== 16'sd0 || dout_valid !== 1'b0 || filled !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dout=%0d valid=%b filled=%b, need 0/0/0", dout, dout_valid, filled);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_ramp(input string tag);
    for (int i = 0; i < 8; i++) begin
      send(16'sd15);
      checks++;
      if (dout !== 16'(RAMP[i]) || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_%0d: dout=%0d valid=%b, need %0d/1", tag, i, dout, dout_valid, RAMP[i]);
      end
      checks++;
      if (filled !== (i == 7)) begin
        errors++;
        $display("FAIL %s_filled_%0d: filled=%b, need %b", tag, i, filled, i == 7);
      end
    end
  endtask

  task automatic test_ramp;
    log2_len = 3'd3;
    run_ramp("ramp");
    @(posedge clk); #1;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL ramp_pulse_width: valid=%b, need 0", dout_valid);
    end
    for (int i = 0; i < 3; i++) send(16'sd15);
    checks++;
    if (dout !== 16'sd15 || filled !== 1'b1) begin
      errors++;
      $display("FAIL ramp_steady: dout=%0d filled=%b, need 15/1", dout, filled);
    end
  endtask

  task automatic test_negative;
    // Flush the window via a window change so the negative run starts empty.
    log2_len = 3'd2; @(posedge clk); #1;
    log2_len = 3'd3; @(posedge clk); #1;
    send(-16'sd15);
    checks++;
    if (dout !== 16'(NEG_FIRST)) begin
      errors++;
      $display("FAIL neg_first: dout=%0d, need %0d", dout, NEG_FIRST);
    end
    for (int i = 0; i < 7; i++) send(-16'sd15);
    checks++;
    if (dout !== -16'sd15 || filled !== 1'b1) begin
      errors++;
      $display("FAIL neg_settle: dout=%0d filled=%b, need -15/1", dout, filled);
    end
  endtask

  task automatic test_impulse;
    log2_len = 3'd2; @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(16'sd0);
    for (int i = 0; i < 7; i++) begin
      send((i == 0) ? 16'sd15 : 16'sd0);
      checks++;
      if (dout !== ((i < 4) ? 16'(IMP) : 16'sd0)) begin
        errors++;
        $display("FAIL impulse_%0d: dout=%0d, need %0d", i, dout, (i < 4) ? IMP : 0);
      end
    end
  endtask

  task automatic test_window_change;
    log2_len = 3'd3;
    for (int i = 0; i < 8; i++) send(16'sd15);
    // Change with ce low: window cleared, no pulse, dout holds.
    log2_len = 3'd1;
    @(posedge clk); #1;
    checks++;
    if (filled !== 1'b0 || dout_valid !== 1'b0 || dout !== 16'sd15) begin
      errors++;
      $display("FAIL wc_idle: filled=%b valid=%b dout=%0d, need 0/0/15", filled, dout_valid, dout);
    end
    send(16'sd15);
    checks++;
    if (dout !== 16'(WC_FIRST) || filled !== 1'b0) begin
      errors++;
      $display("FAIL wc_first: dout=%0d filled=%b, need %0d/0", dout, filled, WC_FIRST);
    end
    send(16'sd15);
    checks++;
    if (dout !== 16'sd15 || filled !== 1'b1) begin
      errors++;
      $display("FAIL wc_second: dout=%0d filled=%b, need 15/1", dout, filled);
    end
    // Refill at 8 (change coincident with the first sample), then change coincident again.
    @(posedge clk); #1;
    ce = 1'b1; din = 16'sd15; log2_len = 3'd3;
    @(posedge clk); #1;
    ce = 1'b0;
    for (int i = 0; i < 7; i++) send(16'sd15);
    checks++;
    if (dout !== 16'sd15 || filled !== 1'b1) begin
      errors++;
      $display("FAIL wc_refill: dout=%0d filled=%b, need 15/1", dout, filled);
    end
    @(posedge clk); #1;
    ce = 1'b1; din = 16'sd15; log2_len = 3'd1;
    @(posedge clk); #1;
    ce = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dout !== 16'(WC_FIRST) || filled !== 1'b0 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL wc_coinc_first: dout=%0d filled=%b valid=%b, need %0d/0/1", dout, filled, dout_valid, WC_FIRST);
    end
    send(16'sd15);
    checks++;
    if (dout !== 16'sd15 || filled !== 1'b1) begin
      errors++;
      $display("FAIL wc_coinc_second: dout=%0d filled=%b, need 15/1", dout, filled);
    end
  endtask

  task automatic test_back_to_back;
    log2_len = 3'd0;
    @(posedge clk); #1;
    ce = 1'b1; din = -16'sd12;
    @(posedge clk); #1;
    din = 16'sd16;
    @(posedge clk); #1;
    ce = 1'b0;
    checks++;
    if (dout !== -16'sd12 || dout_valid !== 1'b1 || filled !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: dout=%0d valid=%b filled=%b, need -12/1/1", dout, dout_valid, filled);
    end
    @(posedge clk); #1;
    checks++;
    if (dout !== 16'sd16 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: dout=%0d valid=%b, need 16/1", dout, dout_valid);
    end
  endtask

  task automatic test_limits;
    log2_len = 3'd7;
    for (int i = 0; i < 31; i++) send(16'sd32767);
    checks++;
    if (filled !== 1'b0) begin
      errors++;
      $display("FAIL clamp_31: filled=%b, need 0", filled);
    end
    send(16'sd32767);
    checks++;
    if (dout !== 16'sd32767 || filled !== 1'b1) begin
      errors++;
      $display("FAIL max_pos: dout=%0d filled=%b, need 32767/1", dout, filled);
    end
    for (int i = 0; i < 32; i++) send(-16'sd32768);
    checks++;
    if (dout !== -16'sd32768) begin
      errors++;
      $display("FAIL max_neg: dout=%0d, need -32768", dout);
    end
  endtask

  task automatic test_wrap;
    log2_len = 3'd5;
    for (int n = 0; n < 100; n++) begin
      send(16'(n % 32));
      if (n >= 31) begin
        checks++;
        if (dout !== 16'(WRAP_AVG) || filled !== 1'b1) begin
          errors++;
          $display("FAIL wrap_%0d: dout=%0d filled=%b, need %0d/1", n, dout, filled, WRAP_AVG);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    log2_len = 3'd2; @(posedge clk); #1;
    log2_len = 3'd3;
    for (int i = 0; i < 8; i++) send(16'sd15);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (dout !== 16'sd0 || dout_valid !== 1'b0 || filled !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: dout=%0d valid=%b filled=%b, need 0/0/0", dout, dout_valid, filled);
    end
    #1 rst = 1'b0;
    run_ramp("post_rst");
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_negative;
    test_impulse;
    test_window_change;
    test_back_to_back;
    test_limits;
    test_wrap;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
